// File: rtl/div_pkg.sv
// Shared types and constants for the EXE-stage iterative divider.
package div_pkg;

  localparam int unsigned DIV_XLEN = 32;

  // Most negative signed dividend; with a divisor of -1 the quotient overflows.
  localparam logic [DIV_XLEN-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

  // Signed flavours treat operands as two's complement.
  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  // Remainder flavours return the remainder instead of the quotient.
  function automatic logic op_is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Unsigned restoring shift-subtract datapath, one quotient bit per step.
// The *_next_c outputs are the combinational result of the step about to
// be taken, so the sequencer can capture the final values on the last edge.
module div_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_next_c,
  output logic [XLEN-1:0] rem_next_c
);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            take;

  // Shift next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    shifted    = {rem_q, quo_q[XLEN-1]};
    diff       = shifted - {1'b0, dvs_q};
    take       = ~diff[XLEN];
    rem_next_c = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_next_c = {quo_q[XLEN-2:0], take};
  end

  // Partial remainder, quotient/dividend shift register and divisor.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= rem_next_c;
      quo_q <= quo_next_c;
    end
  end

endmodule

// File: rtl/div_stall_unit.sv
// RV32M DIV/DIVU/REM/REMU sequencer for the EXE stage. Holds the pipeline
// through divide_stall while div_iter_core iterates, then presents a
// registered, sign-corrected result for one or more DONE cycles.
// Optional build macro: DIV_EARLY_OUT_EN -- divide-by-zero and signed
// overflow skip the iterations and go straight from IDLE to DONE.
module div_stall_unit
  import div_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            div_valid,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  input  logic            stall_ext,
  output logic            divide_stall,
  output logic [XLEN-1:0] div_result,
  output logic            div_result_valid
);

  localparam int unsigned     CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  // Sign bit only, scaled from the package constant to this XLEN.
  localparam logic [XLEN-1:0] OVF_DVD =
    XLEN'({DIV_OVF_DIVIDEND, {XLEN{1'b0}}} >> DIV_XLEN);

  div_state_e      state;
  div_state_e      state_next;
  logic [CNT_W-1:0] count;

  div_op_e         op_in;
  logic            signed_in;
  logic            rs1_neg;
  logic            rs2_neg;
  logic [XLEN-1:0] rs1_abs;
  logic [XLEN-1:0] rs2_abs;
  logic            zero_in;
  logic            ovf_in;
  logic            early_c;
  logic            start_c;

  div_op_e         op_q;
  logic            quo_neg_q;
  logic            rem_neg_q;
  logic            zero_q;
  logic            ovf_q;
  logic [XLEN-1:0] dividend_q;

  logic            core_load;
  logic            core_step;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] rem_next;

  div_op_e         sel_op;
  logic            sel_zero;
  logic            sel_ovf;
  logic [XLEN-1:0] sel_dvd;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] result_c;

  // Decode the incoming operation and its special cases.
  always_comb begin
    op_in     = div_op_e'(div_op);
    signed_in = op_is_signed(op_in);
    rs1_neg   = signed_in & rs1[XLEN-1];
    rs2_neg   = signed_in & rs2[XLEN-1];
    rs1_abs   = rs1_neg ? (~rs1 + XLEN'(1)) : rs1;
    rs2_abs   = rs2_neg ? (~rs2 + XLEN'(1)) : rs2;
    zero_in   = (rs2 == '0);
    ovf_in    = signed_in & (rs1 == OVF_DVD) & (rs2 == '1);
    start_c   = (state == IDLE) & div_valid & ~flush;
  end

`ifdef DIV_EARLY_OUT_EN
  assign early_c = zero_in | ovf_in;
`else
  assign early_c = 1'b0;
`endif

  // Freeze request: starting op in IDLE or iterating; flush releases at once.
  assign divide_stall = reset_n & ~flush &
                        (((state == IDLE) & div_valid) | (state == BUSY));

  // Next-state and datapath control.
  always_comb begin
    state_next = state;
    core_load  = 1'b0;
    core_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start_c) begin
          core_load  = 1'b1;
          state_next = early_c ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          core_step = 1'b1;
          if (count == CNT_LAST) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (flush || !stall_ext) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  div_iter_core #(
    .XLEN (XLEN)
  ) u_core (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (core_load),
    .step       (core_step),
    .dividend   (rs1_abs),
    .divisor    (rs2_abs),
    .quo_next_c (quo_next),
    .rem_next_c (rem_next)
  );

  // Final result: early-out uses live operands, otherwise the latched ones.
  always_comb begin
    sel_op   = op_q;
    sel_zero = zero_q;
    sel_ovf  = ovf_q;
    sel_dvd  = dividend_q;
    if (state == IDLE) begin
      sel_op   = op_in;
      sel_zero = zero_in;
      sel_ovf  = ovf_in;
      sel_dvd  = rs1;
    end
    quo_fix = quo_neg_q ? (~quo_next + XLEN'(1)) : quo_next;
    rem_fix = rem_neg_q ? (~rem_next + XLEN'(1)) : rem_next;
    if (sel_zero) begin
      result_c = op_is_rem(sel_op) ? sel_dvd : '1;
    end else if (sel_ovf) begin
      result_c = op_is_rem(sel_op) ? '0 : OVF_DVD;
    end else begin
      result_c = op_is_rem(sel_op) ? rem_fix : quo_fix;
    end
  end

  // Operation context, iteration counter and registered result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count            <= '0;
      op_q             <= DIV;
      quo_neg_q        <= 1'b0;
      rem_neg_q        <= 1'b0;
      zero_q           <= 1'b0;
      ovf_q            <= 1'b0;
      dividend_q       <= '0;
      div_result       <= '0;
      div_result_valid <= 1'b0;
    end else begin
      if (core_load) begin
        count      <= '0;
        op_q       <= op_in;
        quo_neg_q  <= rs1_neg ^ rs2_neg;
        rem_neg_q  <= rs1_neg;
        zero_q     <= zero_in;
        ovf_q      <= ovf_in;
        dividend_q <= rs1;
      end else if (core_step) begin
        count <= count + CNT_W'(1);
      end
      div_result_valid <= (state_next == DONE);
      if ((state != DONE) && (state_next == DONE)) begin
        div_result <= result_c;
      end
    end
  end

endmodule
